icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, read-only instruction cache between the datapath fetch stage and the memory
//  controller's instruction port. It serves hits combinationally and fills misses with a
//  one-word iREN/iwait transaction. One instance sits upstream of each core's arbiter port.
// PARAMETERS
//  SETS        16   number of one-word lines; power of two, >=2; IDX_W = $clog2(SETS)
//  WORD_W      32   word and address width
// PORTS
//  CLK         in   1        clock, rising edge
//  nRST        in   1        synchronous active-low reset, sampled on CLK rising edge
//  imemREN     in   1        datapath instruction read request
//  imemaddr    in   WORD_W   datapath fetch byte address
//  ihit        out  1        imemload valid this cycle
//  imemload    out  WORD_W   instruction word to the datapath
//  flush       in   1        invalidate all lines (halt or self-modify)
//  iREN        out  1        fill request to the memory controller
//  iaddr       out  WORD_W   fill word address, [1:0] = 2'b00
//  iwait       in   1        memory controller busy; low = iload valid and fill done
//  iload       in   WORD_W   fill data
//  miss_count  out  WORD_W   number of fills started since reset
// BEHAVIOUR
//  Address split:
//  - [1:0] ignored.
//  - index = imemaddr[IDX_W+1:2].
//  - tag = imemaddr[WORD_W-1:IDX_W+2].
//  Storage: per line valid, tag and data registers. There is no write path from the datapath.
//  Reset (nRST low at the edge):
//  - All valid bits go to 0, state goes to IDLE, and miss_count goes to 0.
//  - Outputs: iREN=0, iaddr=0, ihit=0, imemload=0.
//  - Tag and data may be left un-reset.
//  - Reset taken mid-fill abandons the fill, and no line is written.
//  Hit, combinational:
//  - ihit = imemREN & valid[index] & (tag match) & (state==IDLE).
//  - imemload = data[index] when ihit, else 0.
//  - Hit latency is 0 cycles.
//  FSM IDLE:
//  - If imemREN and no hit, latch fill_addr = {imemaddr[WORD_W-1:2],2'b00} and go to FILL.
//  - miss_count increments by 1 on this transition and wraps at 2^WORD_W.
//  FSM FILL:
//  - Drive iREN=1 and iaddr=fill_addr. ihit=0.
//  - On a cycle with iwait=0: write data[fill index]=iload, write tag, set valid=1, go to IDLE.
//  - The fill always completes once started, even if imemREN drops or imemaddr changes. This
//    prevents the controller from stalling in its fetch state with no requester.
//  - If imemREN is still high with the same address, the hit is served the cycle after the fill.
//  - Miss latency is (cycles until iwait low) + 1.
//  - There is no same-cycle forwarding of iload to imemload.
//  iwait is ignored in IDLE. iREN is 0 in IDLE.
//  Flush, synchronous:
//  - Clears all valid bits at the edge. It has priority over a fill write on the same edge, so
//    that line ends up invalid.
//  - A fill in progress continues with its handshake but does not set valid.
//  - ihit is forced 0 during any cycle in which flush=1.
//  Conflict: a fill overwrites whatever line shares the index. There is no victim handling, and
//  lines are never dirty.
// TESTING
//  1) Reset, then imemREN=1 at 0x0000_0040 with iwait low after 3 cycles and iload=0xDEADBEEF:
//     - iREN=1 and iaddr=0x40 for 3 cycles.
//     - ihit=1 and imemload=0xDEADBEEF on the next cycle.
//     - miss_count=1.
//  2) Repeat the read of 0x40, then of 0x42:
//     - ihit=1 the same cycle, iREN stays 0, and miss_count is unchanged.
//  3) Conflict: fill 0x40, then read 0x80 (same index 0, tag differs):
//     - Miss and fill from 0x80.
//     - A re-read of 0x40 misses again, and miss_count=3.
//  4) Drop imemREN and change imemaddr to 0x100 during a fill of 0x40:
//     - iaddr holds 0x40 until iwait low, and line 0x40 becomes valid.
//     - The next cycle starts a fill of 0x100.
//  5) Pulse flush after filling 0x40 and 0x44:
//     - Both re-reads miss.
//     - flush asserted on the iwait-low cycle of a fill leaves that line invalid.
//  6) Assert nRST low mid-fill:
//     - Next cycle iREN=0, ihit=0, and miss_count=0.
//     - A re-read of the same address misses.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache
// Hits are served combinationally; misses fill one word over iREN/iwait.
module icache_direct_mapped #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-3:0]   fill_q, fill_d;
  logic [WORD_W-1:0]   miss_q, miss_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [TAG_W-1:0]    tag_d  [SETS];
  logic [WORD_W-1:0]   data_q [SETS];
  logic [WORD_W-1:0]   data_d [SETS];

  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic                unused_byte_bits;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx = fill_q[IDX_W-1:0];
  assign fill_tag = fill_q[WORD_W-3:IDX_W];
  assign unused_byte_bits = ^imemaddr[1:0];

  assign ihit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                && (state_q == IDLE) && !flush;
  assign imemload   = ihit ? data_q[req_idx] : '0;
  assign miss_count = miss_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    miss_d  = miss_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    iREN    = 1'b0;
    iaddr   = '0;
    case (state_q)
      IDLE: begin
        if (imemREN && !ihit) begin
          fill_d  = imemaddr[WORD_W-1:2];
          miss_d  = miss_q + WORD_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        // Fill runs to completion regardless of imemREN so the controller is never orphaned.
        iREN  = 1'b1;
        iaddr = {fill_q, 2'b00};
        if (!iwait) begin
          data_d[fill_idx]  = iload;
          tag_d[fill_idx]   = fill_tag;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      fill_q  <= '0;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - directed self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;
  logic        CLK = 1'b0;
  logic        nRST, imemREN, flush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, miss_count;
  int n_tests = 0;
  int n_fail  = 0;

  icache_direct_mapped #(.SETS(16), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .flush(flush), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Miss on addr from IDLE, hold iwait high for nbusy cycles, then complete with data.
  task automatic run_fill(input logic [31:0] addr, input logic [31:0] data, input int nbusy);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    tick();
    for (int i = 0; i < nbusy; i++) begin
      iwait = 1'b1;
      tick();
    end
    iwait = 1'b0; iload = data;
    tick();
    iwait = 1'b1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; imemREN = 1'b0; flush = 1'b0; iwait = 1'b1; iload = '0; imemaddr = '0;
    tick();
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN got %0h want 0", iREN); end
    n_tests++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr got %0h want 0", iaddr); end
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit got %0h want 0", ihit); end
    n_tests++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload got %0h want 0", imemload); end
    n_tests++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count got %0h want 0", miss_count); end
  endtask

  task automatic test_first_miss();
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = 32'hDEADBEEF;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL miss_ihit got %0h want 0", ihit); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      iwait = (c == 3) ? 1'b0 : 1'b1;
      #1;
      n_tests++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL fill_iREN c%0d got %0h want 1", c, iREN); end
      n_tests++; if (iaddr !== 32'h40) begin n_fail++; $display("FAIL fill_iaddr c%0d got %0h want 40", c, iaddr); end
      n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL fill_ihit c%0d got %0h want 0", c, ihit); end
      tick();
    end
    iwait = 1'b1;
    #1;
    n_tests++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL after_fill_ihit got %0h want 1", ihit); end
    n_tests++; if (imemload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL after_fill_data got %0h want deadbeef", imemload); end
    n_tests++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL after_fill_count got %0d want 1", miss_count); end
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL after_fill_iREN got %0h want 0", iREN); end
  endtask

  task automatic test_hit();
    logic [31:0] addrs [2];
    addrs[0] = 32'h40; addrs[1] = 32'h42;
    for (int k = 0; k < 2; k++) begin
      imemREN = 1'b1; imemaddr = addrs[k];
      #1;
      n_tests++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL hit_ihit %0h got %0h want 1", addrs[k], ihit); end
      n_tests++; if (imemload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_data %0h got %0h want deadbeef", addrs[k], imemload); end
      tick();
      n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL hit_iREN %0h got %0h want 0", addrs[k], iREN); end
      n_tests++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL hit_count %0h got %0d want 1", addrs[k], miss_count); end
    end
  endtask

  task automatic test_conflict();
    imemREN = 1'b1; imemaddr = 32'h80;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conf_80_ihit got %0h want 0", ihit); end
    tick();
    n_tests++; if (iaddr !== 32'h80) begin n_fail++; $display("FAIL conf_80_iaddr got %0h want 80", iaddr); end
    iwait = 1'b0; iload = 32'h11111111;
    tick();
    iwait = 1'b1;
    #1;
    n_tests++; if (imemload !== 32'h11111111) begin n_fail++; $display("FAIL conf_80_data got %0h want 11111111", imemload); end
    imemaddr = 32'h40;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conf_40_ihit got %0h want 0", ihit); end
    run_fill(32'h40, 32'hDEADBEEF, 0);
    #1;
    n_tests++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL conf_count got %0d want 3", miss_count); end
    n_tests++; if (imemload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL conf_40_data got %0h want deadbeef", imemload); end
  endtask

  task automatic test_fill_completes();
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h40;
    tick();
    imemREN = 1'b0; imemaddr = 32'h100; iwait = 1'b1;
    #1;
    n_tests++; if (iaddr !== 32'h40) begin n_fail++; $display("FAIL hold_iaddr1 got %0h want 40", iaddr); end
    tick();
    iwait = 1'b0; iload = 32'hCAFEF00D;
    #1;
    n_tests++; if (iaddr !== 32'h40) begin n_fail++; $display("FAIL hold_iaddr2 got %0h want 40", iaddr); end
    tick();
    iwait = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    n_tests++; if (imemload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL hold_40_valid got %0h want cafef00d", imemload); end
    imemaddr = 32'h100;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL next_100_ihit got %0h want 0", ihit); end
    tick();
    n_tests++; if (iaddr !== 32'h100 || iREN !== 1'b1) begin n_fail++; $display("FAIL next_100_fill got iaddr %0h iREN %0h want 100/1", iaddr, iREN); end
    n_tests++; if (miss_count !== 32'd2) begin n_fail++; $display("FAIL next_100_count got %0d want 2", miss_count); end
    iwait = 1'b0; iload = 32'h12345678;
    tick();
    iwait = 1'b1;
    #1;
    n_tests++; if (imemload !== 32'h12345678) begin n_fail++; $display("FAIL next_100_data got %0h want 12345678", imemload); end
  endtask

  task automatic test_flush();
    run_fill(32'h40, 32'hA0A0A0A0, 1);
    run_fill(32'h44, 32'hB1B1B1B1, 2);
    imemaddr = 32'h44; imemREN = 1'b1;
    #1;
    n_tests++; if (imemload !== 32'hB1B1B1B1) begin n_fail++; $display("FAIL flush_pre44 got %0h want b1b1b1b1", imemload); end
    imemaddr = 32'h40; flush = 1'b1;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_forces_ihit got %0h want 0", ihit); end
    imemREN = 1'b0;
    tick();
    flush = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_40_ihit got %0h want 0", ihit); end
    run_fill(32'h40, 32'hA0A0A0A0, 0);
    imemaddr = 32'h44;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_44_ihit got %0h want 0", ihit); end
    run_fill(32'h44, 32'hB1B1B1B1, 0);
    imemREN = 1'b1; imemaddr = 32'h48;
    tick();
    iwait = 1'b0; iload = 32'hC2C2C2C2; flush = 1'b1;
    tick();
    iwait = 1'b1; flush = 1'b0;
    #1;
    n_tests++; if (miss_count !== 32'd7) begin n_fail++; $display("FAIL flush_count got %0d want 7", miss_count); end
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_on_fill_ihit got %0h want 0", ihit); end
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL flush_on_fill_idle got iREN %0h want 0", iREN); end
  endtask

  task automatic test_reset_mid_fill();
    run_fill(32'h48, 32'hC2C2C2C2, 0);
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
    tick();
    #1;
    n_tests++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rst_fill_iREN got %0h want 1", iREN); end
    nRST = 1'b0; iwait = 1'b0; iload = 32'hEEEEEEEE; imemREN = 1'b0;
    tick();
    nRST = 1'b1; iwait = 1'b1;
    #1;
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL rst_mid_iREN got %0h want 0", iREN); end
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ihit got %0h want 0", ihit); end
    n_tests++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d want 0", miss_count); end
    imemREN = 1'b1; imemaddr = 32'h200;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rst_reread_ihit got %0h want 0", ihit); end
    tick();
    n_tests++; if (iREN !== 1'b1 || iaddr !== 32'h200) begin n_fail++; $display("FAIL rst_reread_fill got iREN %0h iaddr %0h want 1/200", iREN, iaddr); end
    iwait = 1'b0; iload = 32'h0BADF00D;
    tick();
    iwait = 1'b1;
    #1;
    n_tests++; if (imemload !== 32'h0BADF00D) begin n_fail++; $display("FAIL rst_reread_data got %0h want 0badf00d", imemload); end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_hit();
    test_conflict();
    test_fill_completes();
    test_flush();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
